// File: rtl/reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue
//
// Write-side master for the CPU register file. Results from the ALU and the
// load (memory) path are collected into an in-order FIFO and retired one per
// cycle through a registered register-file write port. A registered
// pending-destination mask tells hazard logic which registers still have a
// write in flight.
//
// When the FIFO is empty at the start of a cycle, the oldest accepted result
// goes straight into the write-port register. This gives one-cycle latency
// from acceptance to write. Every other accepted result is enqueued behind
// older ones, so writes always retire in acceptance order. Results for r0 are
// acknowledged and then dropped.
//
// Ports
//   clk                in   rising-edge clock
//   reset              in   synchronous, active-high reset
//   alu_valid/rd/data  in   ALU result offer
//   alu_ready          out  ALU result accepted when alu_valid & alu_ready
//   mem_valid/rd/data  in   load result offer (older than ALU when both push)
//   mem_ready          out  load result accepted when mem_valid & mem_ready
//   reg_write_enable   out  register-file write strobe (registered)
//   reg_write_address  out  register-file write index (registered)
//   write_data         out  register-file write data (registered)
//   pending_mask       out  bit n set: a write to rn is queued or on the port
//   fifo_count         out  occupied FIFO entries
//
// Optional feature (macro REG_WB_BYPASS_EN)
//   Adds rd_addr_1/2 (in) and fwd_valid_1/2, fwd_data_1/2 (out). These form a
//   combinational forwarding lookup that returns the youngest in-flight value
//   for a register. Without the macro, these ports and comparators do not
//   exist.
// -----------------------------------------------------------------------------
module reg_writeback_queue #(
   parameter int DEPTH  = 4,   // power of 2, >= 2
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alu_valid,
   input  logic [ADDR_W-1:0]          alu_rd,
   input  logic [DATA_W-1:0]          alu_data,
   output logic                       alu_ready,
   input  logic                       mem_valid,
   input  logic [ADDR_W-1:0]          mem_rd,
   input  logic [DATA_W-1:0]          mem_data,
   output logic                       mem_ready,
   output logic                       reg_write_enable,
   output logic [ADDR_W-1:0]          reg_write_address,
   output logic [DATA_W-1:0]          write_data,
   output logic [(2**ADDR_W)-1:0]     pending_mask,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef REG_WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]          rd_addr_1,
   input  logic [ADDR_W-1:0]          rd_addr_2,
   output logic                       fwd_valid_1,
   output logic                       fwd_valid_2,
   output logic [DATA_W-1:0]          fwd_data_1,
   output logic [DATA_W-1:0]          fwd_data_2
`endif
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int NREG = 2**ADDR_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NREG-1:0]   mask_q, mask_d;

   logic [CW-1:0]     free_w;
   logic              mem_push, alu_push;
   logic              port_free;
   logic [PW-1:0]     slot_off;

   // ---------------------------------------------------------------------------
   // Ready logic: uses the registered count only, so the pop in this cycle is
   // not counted. This is conservative, and the queue can never overflow.
   // ---------------------------------------------------------------------------
   assign free_w    = DEPTH_C - count_q;
   assign mem_ready = (free_w >= CW'(1));
   assign alu_ready = (free_w >= CW'(2)) || ((free_w >= CW'(1)) && !mem_valid);

   // A handshake to r0 completes but never reaches the queue.
   assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
   assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);

   // ---------------------------------------------------------------------------
   // Next state. Candidates for the write port, oldest first: the FIFO head,
   // then the mem result, then the ALU result. The oldest candidate takes the
   // port. The rest are enqueued in order.
   // ---------------------------------------------------------------------------
   always_comb begin : next_state
      // NOTE: every variable gets a default at the top of the block; an
      // unassigned path in combinational logic would infer a latch.
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      port_free = 1'b1;

      if (count_q != '0) begin
         we_d      = 1'b1;
         addr_d    = mem_q[rd_ptr_q].rd;
         data_d    = mem_q[rd_ptr_q].data;
         rd_ptr_d  = rd_ptr_q + PW'(1);
         count_d   = count_q - CW'(1);
         port_free = 1'b0;
      end

      // NOTE: blocking assignments here are deliberate: wr_ptr_d and count_d
      // are updated step by step, so the ALU push sees the mem push's slot.
      if (mem_push) begin
         if (port_free) begin
            we_d      = 1'b1;
            addr_d    = mem_rd;
            data_d    = mem_data;
            port_free = 1'b0;
         end else begin
            mem_d[wr_ptr_d] = '{rd: mem_rd, data: mem_data};
            wr_ptr_d        = wr_ptr_d + PW'(1);
            count_d         = count_d + CW'(1);
         end
      end

      if (alu_push) begin
         if (port_free) begin
            we_d      = 1'b1;
            addr_d    = alu_rd;
            data_d    = alu_data;
            port_free = 1'b0;
         end else begin
            mem_d[wr_ptr_d] = '{rd: alu_rd, data: alu_data};
            wr_ptr_d        = wr_ptr_d + PW'(1);
            count_d         = count_d + CW'(1);
         end
      end
   end

   // Pending mask is built from the next state, so it changes on the same edge
   // as the queue and the write port.
   always_comb begin : mask_next
      mask_d   = '0;
      slot_off = '0;
      if (we_d) mask_d[addr_d] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off = PW'(i) - rd_ptr_d;   // age of slot i, relative to head
         if (CW'(slot_off) < count_d) mask_d[mem_d[i].rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         mask_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         mask_q   <= mask_d;
      end
   end

   // NOTE: the storage array is not reset. Reset clears count and pointers, so
   // old contents are never read as valid entries.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign reg_write_enable  = we_q;
   assign reg_write_address = addr_q;
   assign write_data        = data_q;
   assign pending_mask      = mask_q;
   assign fifo_count        = count_q;

`ifdef REG_WB_BYPASS_EN
   // ---------------------------------------------------------------------------
   // Forwarding lookup. The write port is the oldest in-flight value. Queue
   // slots are scanned oldest to youngest, so the last hit is the youngest.
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] data;
   } fwd_t;

   function automatic fwd_t lookup(input logic [ADDR_W-1:0] ra);
      fwd_t          r;
      logic [PW-1:0] idx;
      r.hit  = 1'b0;
      r.data = '0;
      if (ra != '0) begin
         if (we_q && (addr_q == ra)) begin
            r.hit  = 1'b1;
            r.data = data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[idx].rd == ra)) begin
               r.hit  = 1'b1;
               r.data = mem_q[idx].data;
            end
         end
      end
      return r;
   endfunction

   fwd_t fwd_1, fwd_2;

   always_comb begin : forward
      fwd_1 = lookup(rd_addr_1);
      fwd_2 = lookup(rd_addr_2);
   end

   assign fwd_valid_1 = fwd_1.hit;
   assign fwd_data_1  = fwd_1.data;
   assign fwd_valid_2 = fwd_2.hit;
   assign fwd_data_2  = fwd_2.data;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_queue
//
// Directed, table-driven bench for reg_writeback_queue (DEPTH=4, DATA_W=32,
// ADDR_W=5). Each record holds the inputs for one cycle and the expected
// values: the ready outputs before the clock edge, and the registered outputs
// after the edge. The table covers these cases:
//   - single write
//   - a mem/alu pair to the same register
//   - a drop to r0
//   - sustained dual-source pressure with ALU back-pressure and pointer wrap
//   - a reset in the middle of operation with entries queued
// A hand-written sequence covers forwarding when REG_WB_BYPASS_EN is defined.
// -----------------------------------------------------------------------------
module tb_reg_writeback_queue;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        reg_write_enable;
   logic [4:0]  reg_write_address;
   logic [31:0] write_data;
   logic [31:0] pending_mask;
   logic [2:0]  fifo_count;
`ifdef REG_WB_BYPASS_EN
   logic [4:0]  rd_addr_1, rd_addr_2;
   logic        fwd_valid_1, fwd_valid_2;
   logic [31:0] fwd_data_1, fwd_data_2;
`endif

   reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .alu_valid         (alu_valid),
      .alu_rd            (alu_rd),
      .alu_data          (alu_data),
      .alu_ready         (alu_ready),
      .mem_valid         (mem_valid),
      .mem_rd            (mem_rd),
      .mem_data          (mem_data),
      .mem_ready         (mem_ready),
      .reg_write_enable  (reg_write_enable),
      .reg_write_address (reg_write_address),
      .write_data        (write_data),
      .pending_mask      (pending_mask),
      .fifo_count        (fifo_count)
`ifdef REG_WB_BYPASS_EN
      ,
      .rd_addr_1         (rd_addr_1),
      .rd_addr_2         (rd_addr_2),
      .fwd_valid_1       (fwd_valid_1),
      .fwd_valid_2       (fwd_valid_2),
      .fwd_data_1        (fwd_data_1),
      .fwd_data_2        (fwd_data_2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      logic        e_ar;
      logic        e_mr;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
      logic [31:0] e_mask;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic e_ar, input logic e_mr, input logic e_we, input logic [4:0] e_addr,
                      input logic [31:0] e_data, input logic [2:0] e_cnt, input logic [31:0] e_mask);
      vec_t v;
      v = '{rst, av, ard, adat, mv, mrd, mdat, e_ar, e_mr, e_we, e_addr, e_data, e_cnt, e_mask};
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int n);
      @(negedge clk);
      reset     = v.rst;
      alu_valid = v.av;
      alu_rd    = v.ard;
      alu_data  = v.adat;
      mem_valid = v.mv;
      mem_rd    = v.mrd;
      mem_data  = v.mdat;
      #1;
      check($sformatf("v%0d alu_ready", n), 64'(alu_ready), 64'(v.e_ar));
      check($sformatf("v%0d mem_ready", n), 64'(mem_ready), 64'(v.e_mr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d we", n),    64'(reg_write_enable),  64'(v.e_we));
      check($sformatf("v%0d addr", n),  64'(reg_write_address), 64'(v.e_addr));
      check($sformatf("v%0d data", n),  64'(write_data),        64'(v.e_data));
      check($sformatf("v%0d count", n), 64'(fifo_count),        64'(v.e_cnt));
      check($sformatf("v%0d mask", n),  64'(pending_mask),      64'(v.e_mask));
   endtask

   initial begin
      reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef REG_WB_BYPASS_EN
      rd_addr_1 = '0; rd_addr_2 = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset we",    64'(reg_write_enable),  64'd0);
      check("reset addr",  64'(reg_write_address), 64'd0);
      check("reset data",  64'(write_data),        64'd0);
      check("reset count", 64'(fifo_count),        64'd0);
      check("reset mask",  64'(pending_mask),      64'd0);

      //   rst av ard    adat           mv mrd    mdat    | ar mr we addr  data           cnt mask
      // single ALU write: on the port the next cycle, mask only while on the port
      add(0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,    1, 1, 1, 5'd5,  32'hDEADBEEF, 0, 32'h0000_0020);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 0, 5'd5,  32'hDEADBEEF, 0, 32'h0);
      // same-cycle mem/alu to r3: mem (older) first, then alu
      add(0, 1, 5'd3,  32'h22,       1, 5'd3,  32'h11,   1, 1, 1, 5'd3,  32'h11,       1, 32'h0000_0008);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 1, 5'd3,  32'h22,       0, 32'h0000_0008);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 0, 5'd3,  32'h22,       0, 32'h0);
      // r0 destinations complete the handshake and are dropped
      add(0, 1, 5'd0,  32'hFFFF,     0, 5'd0,  32'h0,    1, 1, 0, 5'd3,  32'h22,       0, 32'h0);
      add(0, 1, 5'd9,  32'h99,       1, 5'd0,  32'h77,   1, 1, 1, 5'd9,  32'h99,       0, 32'h0000_0200);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 0, 5'd9,  32'h99,       0, 32'h0);
      // both sources every cycle: alu_ready drops at free=1, alu rd8 retried
      add(0, 1, 5'd2,  32'h102,      1, 5'd1,  32'h101,  1, 1, 1, 5'd1,  32'h101,      1, 32'h0000_0006);
      add(0, 1, 5'd4,  32'h104,      1, 5'd3,  32'h103,  1, 1, 1, 5'd2,  32'h102,      2, 32'h0000_001C);
      add(0, 1, 5'd6,  32'h106,      1, 5'd5,  32'h105,  1, 1, 1, 5'd3,  32'h103,      3, 32'h0000_0078);
      add(0, 1, 5'd8,  32'h108,      1, 5'd7,  32'h107,  0, 1, 1, 5'd4,  32'h104,      3, 32'h0000_00F0);
      add(0, 1, 5'd8,  32'h108,      1, 5'd10, 32'h10A,  0, 1, 1, 5'd5,  32'h105,      3, 32'h0000_04E0);
      add(0, 1, 5'd8,  32'h108,      1, 5'd11, 32'h10B,  0, 1, 1, 5'd6,  32'h106,      3, 32'h0000_0CC0);
      add(0, 1, 5'd8,  32'h108,      0, 5'd0,  32'h0,    1, 1, 1, 5'd7,  32'h107,      3, 32'h0000_0D80);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 1, 5'd10, 32'h10A,      2, 32'h0000_0D00);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 1, 5'd11, 32'h10B,      1, 32'h0000_0900);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 1, 5'd8,  32'h108,      0, 32'h0000_0100);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 0, 5'd8,  32'h108,      0, 32'h0);
      // build up three queued entries, then reset for one cycle
      add(0, 1, 5'd13, 32'h2,        1, 5'd12, 32'h1,    1, 1, 1, 5'd12, 32'h1,        1, 32'h0000_3000);
      add(0, 1, 5'd15, 32'h4,        1, 5'd14, 32'h3,    1, 1, 1, 5'd13, 32'h2,        2, 32'h0000_E000);
      add(0, 1, 5'd17, 32'h6,        1, 5'd16, 32'h5,    1, 1, 1, 5'd14, 32'h3,        3, 32'h0003_C000);
      add(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 0, 5'd0,  32'h0,        0, 32'h0);
      add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 1, 0, 5'd0,  32'h0,        0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef REG_WB_BYPASS_EN
      // r1 goes straight to the port and A5 is queued. Next cycle A5 moves to
      // the port and 5A is queued. r7 is then in flight twice; 5A is youngest.
      @(negedge clk);
      reset = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5;
      @(negedge clk);
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h5A;
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
      rd_addr_1 = 5'd7;
      rd_addr_2 = 5'd0;
      #1;
      check("fwd1 valid", 64'(fwd_valid_1), 64'd1);
      check("fwd1 data",  64'(fwd_data_1),  64'h5A);
      check("fwd2 valid r0", 64'(fwd_valid_2), 64'd0);
      rd_addr_2 = 5'd1;
      #1;
      check("fwd2 valid retired r1", 64'(fwd_valid_2), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
